// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial SRAM responder (READ 0x03 / WRITE 0x02, 24-bit address) with a parallel preload port.
// sclk/mosi/cs_n are 2-flop synchronised and edge-detected, so bus events act 3 clk after the pin changes.
module spi_mem_responder #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs_n,
  output logic                 miso,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t               state_q;
  logic [1:0]           sclk_sync_q, mosi_sync_q, cs_sync_q, sync_vld_q;
  logic                 sclk_prev_q, cs_prev_q;
  logic [4:0]           cnt_q;
  logic [7:0]           sh_q;
  logic [ADDR_BITS-1:0] ptr_q;
  logic                 wr_mode_q, miso_q, busy_q;
  logic [7:0]           mem [DEPTH];

  logic                 sclk_rise, sclk_fall, cs_hi, spi_we;
  logic [7:0]           shift_d, mem_rd;
  logic [ADDR_BITS:0]   ptr_shift_d;

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_hi       = cs_sync_q[1];
  assign shift_d     = {sh_q[6:0], mosi_sync_q[1]};
  assign ptr_shift_d = {ptr_q, mosi_sync_q[1]};
  assign mem_rd      = mem[ptr_q];
  assign spi_we      = sync_vld_q[1] && !cs_hi && (state_q == WRITE) && sclk_rise && (cnt_q == 5'd7);
  assign miso        = miso_q;
  assign busy        = busy_q;

  // cs_n flops reset low so that a cs_n already held low at reset release lands in IGNORE rather than CMD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b00;
      sync_vld_q  <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      sh_q      <= 8'h00;
      ptr_q     <= '0;
      wr_mode_q <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (sync_vld_q[1]) begin
      if (cs_hi) begin
        state_q <= IDLE;
        cnt_q   <= 5'd0;
        miso_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q  <= 1'b1;
            cnt_q   <= 5'd0;
            state_q <= cs_prev_q ? CMD : IGNORE;
          end
          CMD: if (sclk_rise) begin
            sh_q  <= shift_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q     <= 5'd0;
              wr_mode_q <= (shift_d == 8'h02);
              state_q   <= (shift_d == 8'h03 || shift_d == 8'h02) ? ADDR : IGNORE;
            end
          end
          ADDR: if (sclk_rise) begin
            ptr_q <= ptr_shift_d[ADDR_BITS-1:0];
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_q   <= 5'd0;
              state_q <= wr_mode_q ? WRITE : READ;
            end
          end
          // cnt_q==0 marks a byte boundary: the next falling edge fetches mem[ptr_q]
          READ: if (sclk_fall) begin
            if (cnt_q == 5'd0) begin
              miso_q <= mem_rd[7];
              sh_q   <= {mem_rd[6:0], 1'b0};
              cnt_q  <= 5'd1;
            end else begin
              miso_q <= sh_q[7];
              sh_q   <= {sh_q[6:0], 1'b0};
              if (cnt_q == 5'd7) begin
                cnt_q <= 5'd0;
                ptr_q <= ptr_q + 1'b1;
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          WRITE: if (sclk_rise) begin
            sh_q <= shift_d;
            if (cnt_q == 5'd7) begin
              cnt_q <= 5'd0;
              ptr_q <= ptr_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          IGNORE: miso_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (spi_we) begin
      mem[ptr_q] <= shift_d;
    end else if (load_en && !busy_q) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: bit-banged SPI initiator checked against a byte-array memory model.
module tb_spi_mem_responder;
  localparam int DEPTH = 64;
  localparam int AB    = 6;
  localparam int H     = 6;

  logic          clk = 1'b0;
  logic          rst, sclk, mosi, cs_n, miso, load_en, busy;
  logic [AB-1:0] load_addr;
  logic [7:0]    load_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model  [DEPTH];
  logic [7:0] rd_buf [DEPTH];
  logic [7:0] wr_buf [DEPTH];

  spi_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    wait_clk(H);
    r    = miso;
    sclk = 1'b1;
    wait_clk(H);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic spi_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    spi_byte(cmd, d);
    spi_byte(addr[23:16], d);
    spi_byte(addr[15:8], d);
    spi_byte(addr[7:0], d);
  endtask

  task automatic spi_close();
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_read(input logic [23:0] addr, input int n);
    cs_n = 1'b0;
    wait_clk(H);
    spi_hdr(8'h03, addr);
    for (int i = 0; i < n; i++) spi_byte(8'($urandom), rd_buf[i]);
    spi_close();
  endtask

  task automatic spi_write(input logic [23:0] addr, input int n);
    logic [7:0] d;
    cs_n = 1'b0;
    wait_clk(H);
    spi_hdr(8'h02, addr);
    for (int i = 0; i < n; i++) spi_byte(wr_buf[i], d);
    spi_close();
  endtask

  task automatic load_byte(input int a, input logic [7:0] v);
    load_en   = 1'b1;
    load_addr = AB'(a);
    load_data = v;
    wait_clk(1);
    load_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = 8'h00;
    wait_clk(3);
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
    rst = 1'b0;
    wait_clk(4);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL idle_miso got %b want 0", miso); end
  endtask

  task automatic test_preload();
    logic [7:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      load_byte(i, v);
      model[i] = v;
    end
    load_byte(5, 8'hA5); model[5] = 8'hA5;
    load_byte(6, 8'h3C); model[6] = 8'h3C;
    cs_n = 1'b0;
    wait_clk(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_rise_early got %b want 0", busy); end
    wait_clk(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise_3clk got %b want 1", busy); end
    wait_clk(H - 3);
    spi_hdr(8'h03, 24'h000005);
    spi_byte(8'h00, rd_buf[0]);
    spi_byte(8'h00, rd_buf[1]);
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_fall_early got %b want 1", busy); end
    wait_clk(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall_3clk got %b want 0", busy); end
    wait_clk(H);
    checks++;
    if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL preload_rd0 got %h want a5", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== 8'h3C) begin errors++; $display("FAIL preload_rd1 got %h want 3c", rd_buf[1]); end
  endtask

  task automatic test_write();
    wr_buf[0] = 8'hDE; wr_buf[1] = 8'hAD;
    spi_write(24'h000010, 2);
    model[16] = 8'hDE; model[17] = 8'hAD;
    spi_read(24'h000010, 2);
    checks++;
    if (rd_buf[0] !== 8'hDE) begin errors++; $display("FAIL write_rd0 got %h want de", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== 8'hAD) begin errors++; $display("FAIL write_rd1 got %h want ad", rd_buf[1]); end
  endtask

  task automatic test_wrap();
    spi_read(24'h00003F, 2);
    checks++;
    if (rd_buf[0] !== model[63]) begin errors++; $display("FAIL wrap_rd63 got %h want %h", rd_buf[0], model[63]); end
    checks++;
    if (rd_buf[1] !== model[0]) begin errors++; $display("FAIL wrap_rd0 got %h want %h", rd_buf[1], model[0]); end
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
    spi_write(24'h00003F, 2);
    model[63] = 8'h11; model[0] = 8'h22;
    spi_read(24'h000000, 1);
    checks++;
    if (rd_buf[0] !== 8'h22) begin errors++; $display("FAIL wrap_wr0 got %h want 22", rd_buf[0]); end
    spi_read(24'h00003F, 1);
    checks++;
    if (rd_buf[0] !== 8'h11) begin errors++; $display("FAIL wrap_wr63 got %h want 11", rd_buf[0]); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic       r;
    cs_n = 1'b0;
    wait_clk(H);
    spi_hdr(8'h02, 24'h000020);
    spi_byte(8'h55, d);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    wait_clk(H);
    cs_n = 1'b1;
    model[32] = 8'h55;
    wait_clk(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    wait_clk(H);
    spi_read(24'h000020, 2);
    checks++;
    if (rd_buf[0] !== 8'h55) begin errors++; $display("FAIL abort_rd20 got %h want 55", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== model[33]) begin errors++; $display("FAIL abort_rd21 got %h want %h", rd_buf[1], model[33]); end
  endtask

  task automatic test_ignore();
    logic [7:0] d;
    logic       r;
    logic       any_hi;
    any_hi = 1'b0;
    cs_n = 1'b0;
    wait_clk(H);
    spi_byte(8'h9F, d);
    for (int i = 0; i < 32; i++) begin
      spi_bit(1'($urandom), r);
      any_hi = any_hi | (r !== 1'b0);
    end
    checks++;
    if (any_hi !== 1'b0) begin errors++; $display("FAIL ignore_miso got %b want 0", any_hi); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
    spi_close();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    int         a, b;
    logic [7:0] d;
    logic       r;
    logic       any_hi;
    a = $urandom_range(0, DEPTH - 1);
    b = $urandom_range(0, DEPTH - 1);
    any_hi = 1'b0;
    cs_n = 1'b0;
    wait_clk(H);
    spi_hdr(8'h03, 24'(a));
    spi_byte(8'h00, d);
    checks++;
    if (d !== model[a]) begin errors++; $display("FAIL rstmid_first got %h want %h", d, model[a]); end
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    rst = 1'b1;
    #1;
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b want 0", miso); end
    wait_clk(2);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      spi_bit(1'b1, r);
      any_hi = any_hi | (r !== 1'b0);
    end
    checks++;
    if (any_hi !== 1'b0) begin errors++; $display("FAIL rstmid_tail got %b want 0", any_hi); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", busy); end
    load_byte(b, ~model[b]);
    spi_close();
    spi_read(24'(b), 1);
    checks++;
    if (rd_buf[0] !== model[b]) begin errors++; $display("FAIL busy_load got %h want %h", rd_buf[0], model[b]); end
  endtask

  task automatic test_random();
    logic [23:0] addr;
    int          n;
    for (int t = 0; t < 8; t++) begin
      addr = 24'($urandom);
      n    = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
        spi_write(addr, n);
        for (int i = 0; i < n; i++) model[(int'(addr) + i) % DEPTH] = wr_buf[i];
      end else begin
        spi_read(addr, n);
        for (int i = 0; i < n; i++) begin
          checks++;
          if (rd_buf[i] !== model[(int'(addr) + i) % DEPTH]) begin
            errors++;
            $display("FAIL rand_rd addr %h byte %0d got %h want %h", addr, i, rd_buf[i],
                     model[(int'(addr) + i) % DEPTH]);
          end
        end
      end
    end
  endtask

  task automatic test_dump();
    spi_read(24'hFFFFC0, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_buf[i] !== model[i]) begin
        errors++;
        $display("FAIL dump addr %0d got %h want %h", i, rd_buf[i], model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write();
    test_wrap();
    test_abort();
    test_ignore();
    test_reset_mid_read();
    test_random();
    test_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
